// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate type codes, RV opcodes and FIFO entry layout
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_U    = 3'b010,
        IMM_Z    = 3'b011,
        IMM_SH   = 3'b100,
        IMM_B    = 3'b101,
        IMM_J    = 3'b110,
        IMM_NONE = 3'b111
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Entries always carry a 64-bit immediate; narrower datapaths use the low XLEN bits.
    localparam int IMM_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_type_e            imm_type;
        logic                 illegal;
    } imm_entry_t;

    localparam imm_entry_t ENTRY_RESET = '{imm: '0, imm_type: IMM_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational type decode and immediate extraction
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic [31:0] i_inst,
    input  logic [2:0]  i_imm_src,
    output imm_entry_t  o_entry
);

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    imm_type_e            w_dec_type;
    logic                 w_dec_illegal;
    logic                 w_dec_sh5;
    imm_type_e            w_type;
    logic                 w_illegal;
    logic                 w_sh5;
    logic [IMM_MAX_W-1:0] w_imm;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];

    always_comb begin
        w_dec_type    = IMM_NONE;
        w_dec_illegal = 1'b0;
        w_dec_sh5     = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            w_dec_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OP_LOAD, OP_JALR: w_dec_type = IMM_I;
                OP_IMM: w_dec_type = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? IMM_SH : IMM_I;
                OP_IMM32: begin
                    // Word shifts on RV64 only ever take a 5-bit shamt.
                    if (XLEN == 64) begin
                        w_dec_type = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? IMM_SH : IMM_I;
                        w_dec_sh5  = 1'b1;
                    end else begin
                        w_dec_illegal = 1'b1;
                    end
                end
                OP_STORE:          w_dec_type = IMM_S;
                OP_BRANCH:         w_dec_type = IMM_B;
                OP_LUI, OP_AUIPC:  w_dec_type = IMM_U;
                OP_JAL:            w_dec_type = IMM_J;
                OP_SYSTEM:         w_dec_type = w_funct3[2] ? IMM_Z : IMM_I;
                OP_REG, OP_FENCE:  w_dec_type = IMM_NONE;
                OP_REG32:          w_dec_illegal = (XLEN != 64);
                default:           w_dec_illegal = 1'b1;
            endcase
        end
    end

    assign w_type    = AUTO_DECODE ? w_dec_type : imm_type_e'(i_imm_src);
    assign w_illegal = AUTO_DECODE ? w_dec_illegal : 1'b0;
    assign w_sh5     = AUTO_DECODE && w_dec_sh5;

    always_comb begin
        w_imm = '0;
        case (w_type)
            IMM_I:  w_imm = {{52{i_inst[31]}}, i_inst[31:20]};
            IMM_S:  w_imm = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:  w_imm = {{51{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U:  w_imm = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
            IMM_J:  w_imm = {{43{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            IMM_Z:  w_imm = {59'b0, i_inst[19:15]};
            IMM_SH: begin
                if (XLEN == 64 && !w_sh5) w_imm = {58'b0, i_inst[25:20]};
                else                      w_imm = {59'b0, i_inst[24:20]};
            end
            default: w_imm = '0;
        endcase
    end

    assign o_entry = '{imm: w_imm, imm_type: w_type, illegal: w_illegal};

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with valid/ready input and DEPTH-entry output FIFO
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_imm_src,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    imm_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    imm_entry_t       w_new_entry;
    imm_entry_t       w_head;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    imm_extract #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_extract (
        .i_inst    (in_inst),
        .i_imm_src (in_imm_src),
        .o_entry   (w_new_entry)
    );

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_new_entry;
    end

    // An empty FIFO presents the reset entry rather than whatever the head slot still holds.
    assign w_head      = out_valid ? r_mem[r_rd_ptr] : ENTRY_RESET;
    assign out_imm     = w_head.imm[XLEN-1:0];
    assign out_type    = w_head.imm_type;
    assign out_illegal = w_head.illegal;

    generate
        if (XLEN < IMM_MAX_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_head.imm[IMM_MAX_W-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_src;
    logic        flush;
    logic        out_ready;

    logic        rdy32, v32, il32;
    logic [31:0] imm32;
    logic [2:0]  ty32;
    logic        rdy64, v64, il64;
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic        rdye, ve, ile;
    logic [31:0] imme;
    logic [2:0]  tye;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1'b1)) u32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst),
        .in_imm_src(in_imm_src), .flush(flush), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(ty32), .out_illegal(il32));

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .AUTO_DECODE(1'b1)) u64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst),
        .in_imm_src(in_imm_src), .flush(flush), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(ty64), .out_illegal(il64));

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1'b0)) uext (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdye), .in_inst(in_inst),
        .in_imm_src(in_imm_src), .flush(flush), .out_valid(ve), .out_ready(out_ready),
        .out_imm(imme), .out_type(tye), .out_illegal(ile));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] ex32;
        logic [2:0]  ty32;
        logic        il32;
        logic [63:0] ex64;
        logic [2:0]  ty64;
        logic        il64;
        logic [31:0] exe;
    } vec_t;

    vec_t vecs [19];
    logic [31:0] got [$];

    initial begin
        vecs = '{
            '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0, 32'hFFFFFFE1},
            '{32'h00112623, 3'd0, 32'h0000000C, 3'd1, 1'b0, 64'h000000000000000C, 3'd1, 1'b0, 32'h00000001},
            '{32'hFE000CE3, 3'd6, 32'hFFFFFFF8, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0, 32'hFFF007E0},
            '{32'h300FD073, 3'd3, 32'h0000001F, 3'd3, 1'b0, 64'h000000000000001F, 3'd3, 1'b0, 32'h0000001F},
            '{32'h0000007F, 3'd7, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1, 32'h00000000},
            '{32'h800002B7, 3'd5, 32'h80000000, 3'd2, 1'b0, 64'hFFFFFFFF80000000, 3'd2, 1'b0, 32'hFFFFF804},
            '{32'h03F0D093, 3'd4, 32'h0000001F, 3'd4, 1'b0, 64'h000000000000003F, 3'd4, 1'b0, 32'h0000001F},
            '{32'hFFF0809B, 3'd7, 32'h00000000, 3'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0, 32'h00000000},
            '{32'h03F0909B, 3'd7, 32'h00000000, 3'd7, 1'b1, 64'h000000000000001F, 3'd4, 1'b0, 32'h00000000},
            '{32'h0000003B, 3'd7, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b0, 32'h00000000},
            '{32'h00208033, 3'd7, 32'h00000000, 3'd7, 1'b0, 64'h0000000000000000, 3'd7, 1'b0, 32'h00000000},
            '{32'h8000006F, 3'd2, 32'hFFF00000, 3'd6, 1'b0, 64'hFFFFFFFFFFF00000, 3'd6, 1'b0, 32'h80000000},
            '{32'h0080006F, 3'd7, 32'h00000008, 3'd6, 1'b0, 64'h0000000000000008, 3'd6, 1'b0, 32'h00000000},
            '{32'hFFF00090, 3'd7, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1, 32'h00000000},
            '{32'h00412083, 3'd7, 32'h00000004, 3'd0, 1'b0, 64'h0000000000000004, 3'd0, 1'b0, 32'h00000000},
            '{32'hFF0080E7, 3'd7, 32'hFFFFFFF0, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFFF0, 3'd0, 1'b0, 32'h00000000},
            '{32'h12345097, 3'd7, 32'h12345000, 3'd2, 1'b0, 64'h0000000012345000, 3'd2, 1'b0, 32'h00000000},
            '{32'h0FF0000F, 3'd7, 32'h00000000, 3'd7, 1'b0, 64'h0000000000000000, 3'd7, 1'b0, 32'h00000000},
            '{32'h30002573, 3'd7, 32'h00000300, 3'd0, 1'b0, 64'h0000000000000300, 3'd0, 1'b0, 32'h00000000}
        };

        reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_imm_src = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(v32), 64'd0);
        chk("reset out_imm", 64'(imm32), 64'd0);
        chk("reset out_type", 64'(ty32), 64'd7);
        chk("reset out_illegal", 64'(il32), 64'd0);
        chk("reset in_ready", 64'(rdy32), 64'd1);
        chk("reset out_imm64", imm64, 64'd0);
        reset = 1'b0;

        // Table: one instruction at a time, checked one cycle after acceptance.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = vecs[i].inst; in_imm_src = vecs[i].src;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d valid32", i), 64'(v32), 64'd1);
            chk($sformatf("v%0d imm32", i), 64'(imm32), 64'(vecs[i].ex32));
            chk($sformatf("v%0d type32", i), 64'(ty32), 64'(vecs[i].ty32));
            chk($sformatf("v%0d ill32", i), 64'(il32), 64'(vecs[i].il32));
            chk($sformatf("v%0d imm64", i), imm64, vecs[i].ex64);
            chk($sformatf("v%0d type64", i), 64'(ty64), 64'(vecs[i].ty64));
            chk($sformatf("v%0d ill64", i), 64'(il64), 64'(vecs[i].il64));
            chk($sformatf("v%0d immext", i), 64'(imme), 64'(vecs[i].exe));
            chk($sformatf("v%0d typeext", i), 64'(tye), 64'(vecs[i].src));
            chk($sformatf("v%0d illext", i), 64'(ile), 64'd0);
        end
        @(negedge clk);
        chk("empty after table", 64'(v32), 64'd0);

        // Backpressure: A and B fill the FIFO, C waits, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093;
        @(negedge clk);
        in_inst = 32'h00112623;
        @(negedge clk);
        chk("full in_ready", 64'(rdy32), 64'd0);
        chk("full head imm", 64'(imm32), 64'hFFFFFFFF);
        in_inst = 32'h0080006F;
        @(negedge clk);
        chk("held in_ready", 64'(rdy32), 64'd0);
        chk("held head imm", 64'(imm32), 64'hFFFFFFFF);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            bit acc;
            if (v32 && out_ready) got.push_back(imm32);
            acc = in_valid && rdy32;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("drain count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("drain A", 64'(got[0]), 64'hFFFFFFFF);
            chk("drain B", 64'(got[1]), 64'h0000000C);
            chk("drain C", 64'(got[2]), 64'h00000008);
        end

        // Streaming: 16 back-to-back addi with imm = index.
        begin
            int first_cyc, last_cyc, rdy_low;
            first_cyc = -1; last_cyc = -1; rdy_low = 0;
            got.delete();
            for (int c = 0; c < 18; c++) begin
                @(negedge clk);
                if (v32) begin
                    got.push_back(imm32);
                    if (first_cyc < 0) first_cyc = c;
                    last_cyc = c;
                end
                if (!rdy32) rdy_low++;
                if (c < 16) begin
                    in_valid = 1'b1;
                    in_inst = {12'(c), 5'd0, 3'b000, 5'd1, 7'h13};
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("stream count", 64'(got.size()), 64'd16);
            chk("stream span", 64'(last_cyc - first_cyc), 64'd15);
            chk("stream in_ready low", 64'(rdy_low), 64'd0);
            for (int k = 0; k < got.size(); k++)
                chk($sformatf("stream imm%0d", k), 64'(got[k]), 64'(k));
        end

        // Flush with two buffered entries and a same-cycle input.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF00093;
        @(negedge clk);
        in_inst = 32'h00112623;
        @(negedge clk);
        chk("pre-flush valid", 64'(v32), 64'd1);
        flush = 1'b1; in_inst = 32'h0080006F;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", 64'(v32), 64'd0);
        chk("flush in_ready", 64'(rdy32), 64'd1);
        chk("flush out_type", 64'(ty32), 64'd7);
        chk("flush out_imm", 64'(imm32), 64'd0);
        // Flush with one entry and room to accept: the offered input must still be dropped.
        in_valid = 1'b1; in_inst = 32'hFFF00093;
        @(negedge clk);
        flush = 1'b1; in_inst = 32'h00112623;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1 out_valid", 64'(v32), 64'd0);
        @(negedge clk);
        chk("flush1 dropped", 64'(v32), 64'd0);

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; in_inst = 32'hFFF00093;
        @(negedge clk);
        in_inst = 32'h00112623;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset valid", 64'(v32), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset valid", 64'(v32), 64'd0);
        chk("async reset type", 64'(ty32), 64'd7);
        chk("async reset imm", 64'(imm32), 64'd0);
        chk("async reset in_ready", 64'(rdy32), 64'd1);
        chk("async reset valid64", 64'(v64), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset valid", 64'(v32), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, buffered immediate generator for the RV32I/RV64I datapath, placed between fetch/decode and execute.
Accepts instructions over a valid/ready handshake and extracts the sign- or zero-extended immediate to XLEN bits. The immediate type comes from an external ImmSrc code or is decoded from the opcode.
Results pass through a DEPTH-entry output FIFO, so decode can run ahead of a stalled execute stage.
Adds CSR zimm and shift-amount forms and an illegal-encoding flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
DEPTH, 2, output FIFO entries; legal range 1..8.
AUTO_DECODE, 1, 1 = derive type from opcode/funct3 and ignore in_imm_src; 0 = use in_imm_src.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  block can accept; high when FIFO count < DEPTH
in_inst  in  32  instruction word
in_imm_src  in  3  external type code, used when AUTO_DECODE=0
flush  in  1  synchronous discard of all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_imm  out  XLEN  extended immediate of head entry
out_type  out  3  type code of head entry
out_illegal  out  1  head entry encoding was illegal

Behaviour:
- Reset/flush policy: clk with asynchronous, active-high reset. Reset clears FIFO pointers and count. Outputs under reset: out_valid=0, out_imm=0, out_type=3'b111, out_illegal=0, in_ready=1.
- Type codes: 000 I; 001 S; 010 U; 011 Z; 100 SH; 101 B; 110 J; 111 NONE.
- I: sign-extend inst[31:20].
- S: sign-extend {inst[31:25],inst[11:7]}.
- B: sign-extend {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- U: sign-extend {inst[31:12],12'b0}.
- J: sign-extend {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Z: zero-extend inst[19:15].
- SH: zero-extend inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
- NONE: 0.
- Auto-decode by opcode:
  - 0000011 and 1100111 -> I.
  - 0010011: funct3 001/101 -> SH, otherwise I.
  - 0011011 (XLEN=64 only): funct3 001/101 -> SH (5-bit), otherwise I.
  - 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J.
  - 1110011: funct3[2]=1 -> Z, otherwise I.
  - 0110011/0111011/0001111 -> NONE.
  - Any other opcode, or inst[1:0] != 2'b11 -> NONE with illegal=1.
  - XLEN=32: 0011011/0111011 are illegal.
- External mode: code 111 gives illegal=0.
- Push: in_valid && in_ready && !flush writes {imm,type,illegal} at the tail.
- Pop: out_valid && out_ready advances the head.
- Latency: exactly 1 cycle from accepting edge to out_valid. There is no combinational bypass.
- Throughput: 1 per cycle when out_ready=1.
- in_ready depends only on the registered count; there is no combinational path from out_ready.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Full: in_ready=0; in_inst is ignored.
- Empty: out_valid=0 and out_imm/out_type/out_illegal are driven to their reset values (not stale data).
- Pointers wrap modulo DEPTH. This works for non-power-of-2 DEPTH.
- Flush has priority over push and pop. Next cycle count=0 and out_valid=0; any same-cycle input is dropped.
- Reset asserted mid-stream discards all entries immediately (asynchronous).

Decomposition:
- Package imm_pkg:
  - imm_type_e enum with the 3-bit codes above.
  - Opcode localparams (OP_LOAD, OP_IMM, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_REG, OP_REG32, OP_FENCE).
  - Packed struct imm_entry_t {imm, type, illegal}.
- Sub-module imm_extract: combinational, parametrised by XLEN. Decodes type and illegal, then extracts the immediate.
- imm_gen_pipe holds the handshake, FIFO storage, pointers and count.

Test Plan:
1. AUTO, XLEN=32, out_ready=1. in_inst 0xFFF00093 (addi -1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=000. Then 0x00112623 (sw 12) -> out_imm=0x0000000C, out_type=001.
2. 0xFE000CE3 (beq -8) -> out_imm=0xFFFFFFF8, type 101. 0x300FD073 (csrrwi zimm 31) -> out_imm=0x0000001F, type 011. 0x0000007F -> out_illegal=1, out_imm=0.
3. XLEN=64: 0x800002B7 (lui) -> out_imm=0xFFFFFFFF80000000. 0x03F0D093 (srli 63) -> out_imm=63, type 100.
4. DEPTH=2, out_ready=0. Push A and B -> in_ready=0 after the second accept; C held with in_valid=1. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
5. Steady streaming of 16 back-to-back instructions with out_ready=1 -> 16 outputs in 16 consecutive cycles; count never exceeds 1.
6. Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped. Reset pulsed with entries buffered -> outputs return to reset values immediately.
